// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared parameters and state type for the CNN operand sequencer
package cnn_pkg;

  localparam int DW      = 4;
  localparam int TAPS    = 3;
  localparam int OUTS    = 5;
  localparam int DRAIN   = 2;
  localparam int IMG_LEN = OUTS + TAPS - 1;
  localparam int BEATS   = TAPS + IMG_LEN;

  localparam int BEAT_W  = $clog2(BEATS);
  localparam int TAP_W   = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int OUT_W   = 3;
  localparam int IMG_W   = $clog2(IMG_LEN);
  localparam int DRN_W   = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  // Terminal values; counters stop here rather than wrapping.
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(TAPS - 1);
  localparam logic [OUT_W-1:0]  OUT_LAST  = OUT_W'(OUTS - 1);
  localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(DRAIN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/operand_buffer.sv
// rtl/operand_buffer.sv - register array holding TAPS weights followed by IMG_LEN image samples
//   clk, rst_n   clock, synchronous active-low clear of all entries
//   we_i         write strobe
//   widx_i       write address (beat number: weights first, then samples)
//   wdata_i      write data
//   img_idx_i    image sample index (0..IMG_LEN-1), combinational read to img_o
//   w_idx_i      weight index (0..TAPS-1), combinational read to w_o
module operand_buffer
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [BEAT_W-1:0] widx_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic [IMG_W-1:0]  img_idx_i,
  input  logic [TAP_W-1:0]  w_idx_i,
  output logic [DW-1:0]     img_o,
  output logic [DW-1:0]     w_o
);

  logic [DW-1:0] mem_q [BEATS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BEATS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  // Samples live directly above the weights in the same array.
  assign img_o = mem_q[BEAT_W'(TAPS) + BEAT_W'(img_idx_i)];
  assign w_o   = mem_q[BEAT_W'(w_idx_i)];

endmodule

// File: rtl/conv_operand_sequencer.sv
// rtl/conv_operand_sequencer.sv - loads weights/samples from a stream and replays them to the CNN datapath
//   clk, rst_n       clock, synchronous active-low reset
//   go               start a pass (only acted on in IDLE)
//   s_valid/s_ready  operand stream handshake, s_data is the beat payload
//   Start            write strobe with the Image/Filter operand pair
//   ReadEn           read strobe with out_idx naming the result
//   busy, done       pass in progress / one-cycle end-of-pass pulse
module conv_operand_sequencer
  import cnn_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          Start,
  output logic [DW-1:0] Image,
  output logic [DW-1:0] Filter,
  output logic          ReadEn,
  output logic [2:0]    out_idx,
  output logic          busy,
  output logic          done
);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [TAP_W-1:0]  t_q, t_d;
  logic [OUT_W-1:0]  o_q, o_d;
  logic [OUT_W-1:0]  r_q, r_d;
  logic [DRN_W-1:0]  dc_q, dc_d;
  logic              we;
  logic [DW-1:0]     img_rd, w_rd;

  logic          start_q, readen_q, busy_q, done_q;
  logic [DW-1:0] image_q, filter_q;
  logic [2:0]    out_idx_q;

  assign s_ready = (state_q == ST_LOAD);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    t_d     = t_q;
    o_d     = o_q;
    r_d     = r_q;
    dc_d    = dc_q;
    we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_LOAD;
          beat_d  = '0;
        end
      end
      ST_LOAD: begin
        if (s_valid) begin
          we = 1'b1;
          if (beat_q == BEAT_LAST) begin
            state_d = ST_ISSUE;
            t_d     = '0;
            o_d     = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (t_q == TAP_LAST) begin
          if (o_q == OUT_LAST) begin
            state_d = ST_READ;
            r_d     = '0;
          end else begin
            t_d = '0;
            o_d = o_q + 1'b1;
          end
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      ST_READ: begin
        if (r_q == OUT_LAST) begin
          state_d = ST_DRAIN;
          dc_d    = '0;
        end else begin
          r_d = r_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (dc_q == DRN_LAST) state_d = ST_DONE;
        else                  dc_d    = dc_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Buffer is read with the next-cycle counters so the registered
  // operands line up with the state they belong to.
  operand_buffer u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (we),
    .widx_i    (beat_q),
    .wdata_i   (s_data),
    .img_idx_i (IMG_W'(o_d) + IMG_W'(t_d)),
    .w_idx_i   (t_d),
    .img_o     (img_rd),
    .w_o       (w_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      t_q       <= '0;
      o_q       <= '0;
      r_q       <= '0;
      dc_q      <= '0;
      start_q   <= 1'b0;
      image_q   <= '0;
      filter_q  <= '0;
      readen_q  <= 1'b0;
      out_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      t_q       <= t_d;
      o_q       <= o_d;
      r_q       <= r_d;
      dc_q      <= dc_d;
      start_q   <= (state_d == ST_ISSUE);
      image_q   <= (state_d == ST_ISSUE) ? img_rd : '0;
      filter_q  <= (state_d == ST_ISSUE) ? w_rd : '0;
      readen_q  <= (state_d == ST_READ);
      out_idx_q <= (state_d == ST_READ) ? r_d : '0;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign Start   = start_q;
  assign Image   = image_q;
  assign Filter  = filter_q;
  assign ReadEn  = readen_q;
  assign out_idx = out_idx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_conv_operand_sequencer.sv
// tb/tb_conv_operand_sequencer.sv - self-checking bench for conv_operand_sequencer
module tb_conv_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, go, s_valid, s_ready, Start, ReadEn, busy, done;
  logic [3:0] s_data, Image, Filter;
  logic [2:0] out_idx;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] cur_w  [3];
  logic [3:0] cur_im [7];

  typedef struct {
    logic [3:0] w   [3];
    logic [3:0] im  [7];
    int         stall;
    int         res [5];
    int         load_cycles;
  } vec_t;

  vec_t tbl [3];

  always #5 clk = ~clk;

  conv_operand_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .Start   (Start),
    .Image   (Image),
    .Filter  (Filter),
    .ReadEn  (ReadEn),
    .out_idx (out_idx),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: result o is the dot product of the filter with the window starting at o.
  function automatic int model_res(input int o);
    int s = 0;
    for (int t = 0; t < 3; t++) s += int'(cur_im[o + t]) * int'(cur_w[t]);
    return s;
  endfunction

  task automatic run_pass(input string tag, input int stall, input int abort_n,
                          input bit go_in_read, input int exp_res [5],
                          input int exp_load, input bit idle_stress);
    logic [3:0] beats [10];
    int bi = 0, load_cyc = 0, n_start = 0, n_read = 0;
    int first_start = -1, last_start = -1, last_read = -1, last_beat = -1, done_cyc = -1;
    int busy_bad = 0, both_bad = 0, idle_bad = 0, quiet_bad = 0;
    bit prev_ready = 1'b0, fin = 1'b0;
    int got_img [$];
    int got_flt [$];
    int got_idx [$];
    int sum;
    for (int k = 0; k < 10; k++) beats[k] = (k < 3) ? cur_w[k] : cur_im[k - 3];
    @(negedge clk);
    go = 1'b1;
    s_valid = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      go = 1'b0;
      if (prev_ready && s_valid) begin
        bi++;
        if (bi == 10) last_beat = cyc;
      end
      if (!busy) busy_bad++;
      if (Start && ReadEn) both_bad++;
      if (s_ready) load_cyc++;
      if (Start) begin
        got_img.push_back(int'(Image));
        got_flt.push_back(int'(Filter));
        if (first_start < 0) first_start = cyc;
        last_start = cyc;
        n_start++;
        if (abort_n > 0 && n_start == abort_n) begin
          rst_n = 1'b0;
          s_valid = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          check({tag, " abort_outputs_zero"},
                {Start, Image, Filter, ReadEn, out_idx, busy, done, s_ready}, 32'd0);
          return;
        end
      end else if (Image != 4'd0 || Filter != 4'd0) idle_bad++;
      if (ReadEn) begin
        got_idx.push_back(int'(out_idx));
        last_read = cyc;
        n_read++;
        if (go_in_read && n_read == 2) go = 1'b1;
      end else if (out_idx != 3'd0) idle_bad++;
      if (done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end
      prev_ready = s_ready;
      if (s_ready && bi < 10) begin
        case (stall)
          0:       s_valid = 1'b1;
          1:       s_valid = (load_cyc % 2 == 0);
          default: s_valid = 1'($urandom_range(1, 0));
        endcase
        s_data = beats[bi];
      end else begin
        s_valid = 1'b0;
      end
    end
    check({tag, " done_seen"}, 32'(fin), 32'd1);
    check({tag, " start_count"}, n_start, 15);
    check({tag, " readen_count"}, n_read, 5);
    for (int n = 0; n < 15; n++) begin
      int ei = int'(cur_im[n / 3 + n % 3]);
      int ef = int'(cur_w[n % 3]);
      int gi = (got_img.size() > n) ? got_img[n] : -1;
      int gf = (got_flt.size() > n) ? got_flt[n] : -1;
      check($sformatf("%s pair%0d", tag, n), gi * 16 + gf, ei * 16 + ef);
    end
    for (int o = 0; o < 5; o++) begin
      sum = 0;
      for (int t = 0; t < 3; t++)
        if (got_img.size() > o * 3 + t) sum += got_img[o * 3 + t] * got_flt[o * 3 + t];
      check($sformatf("%s result%0d", tag, o), sum, exp_res[o]);
      check($sformatf("%s out_idx%0d", tag, o), (got_idx.size() > o) ? got_idx[o] : -1, o);
    end
    check({tag, " issue_follows_load"}, first_start, last_beat);
    check({tag, " issue_no_bubbles"}, last_start - first_start, 14);
    check({tag, " read_follows_issue"}, last_read - 4, last_start + 1);
    check({tag, " done_latency"}, done_cyc - last_read, 3);
    check({tag, " busy_through_pass"}, busy_bad, 0);
    check({tag, " start_readen_exclusive"}, both_bad, 0);
    check({tag, " operands_zero_when_idle"}, idle_bad, 0);
    if (exp_load > 0) check({tag, " load_cycles"}, load_cyc, exp_load);
    for (int i = 0; i < (idle_stress ? 30 : 3); i++) begin
      @(negedge clk);
      if (s_ready || busy || Start || ReadEn || done) quiet_bad++;
      if (idle_stress) begin
        s_valid = 1'b1;
        s_data  = 4'($urandom_range(15, 0));
      end
    end
    s_valid = 1'b0;
    check({tag, " idle_quiet"}, quiet_bad, 0);
  endtask

  initial begin
    int mres [5];
    rst_n = 1'b0;
    go = 1'b1;
    s_valid = 1'b1;
    s_data = 4'd9;
    repeat (3) @(negedge clk);
    check("reset_outputs_zero",
          {Start, Image, Filter, ReadEn, out_idx, busy, done, s_ready}, 32'd0);
    rst_n = 1'b1;
    go = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {busy, s_ready}, 32'd0);

    tbl[0].w = '{4'd1, 4'd2, 4'd3};
    for (int k = 0; k < 7; k++) tbl[0].im[k] = 4'(k + 1);
    tbl[0].stall = 0;
    tbl[0].res = '{14, 20, 26, 32, 38};
    tbl[0].load_cycles = 10;
    tbl[1] = tbl[0];
    tbl[1].stall = 1;
    tbl[1].load_cycles = 20;
    tbl[2].w = '{4'd15, 4'd15, 4'd15};
    for (int k = 0; k < 7; k++) tbl[2].im[k] = 4'd15;
    tbl[2].stall = 0;
    tbl[2].res = '{675, 675, 675, 675, 675};
    tbl[2].load_cycles = 10;

    for (int v = 0; v < 3; v++) begin
      cur_w = tbl[v].w;
      cur_im = tbl[v].im;
      run_pass($sformatf("tbl%0d", v), tbl[v].stall, 0, 1'b0, tbl[v].res, tbl[v].load_cycles, 1'b0);
    end

    cur_w = tbl[0].w;
    cur_im = tbl[0].im;
    run_pass("abort", 0, 8, 1'b0, tbl[0].res, 0, 1'b0);
    run_pass("after_abort", 0, 0, 1'b0, tbl[0].res, 10, 1'b0);
    run_pass("go_in_read", 0, 0, 1'b1, tbl[0].res, 10, 1'b1);

    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) cur_w[k] = 4'($urandom_range(15, 0));
      for (int k = 0; k < 7; k++) cur_im[k] = 4'($urandom_range(15, 0));
      for (int o = 0; o < 5; o++) mres[o] = model_res(o);
      run_pass($sformatf("rand%0d", r), 2, 0, 1'b0, mres, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
